inst_fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register that feeds the opcode-driven control unit and the register file. The block holds the PC, issues single-outstanding word reads to instruction memory, and buffers returned instructions in an output register plus a one-entry skid slot so downstream stalls never lose a word. It splits each held instruction into MIPS fields and squashes wrong-path fetches on a branch/jump redirect.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/if_skid.sv | 55 +++++
 rtl/inst_fetch.sv | 183 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, NOP word, fetch FSM encoding
// and the immediate sign-extension helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/if_skid.sv
// One-entry skid slot holding an instruction word and its pc+4.
// Load wins over unload so a same-cycle unload/refill keeps it full.
module if_skid
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [31:0]       in_data,
    input  logic [ADDR_W-1:0] in_pc4,
    output logic              valid,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_pc4
);

    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            pc4_d   = in_pc4;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= NOP_WORD;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid    = valid_q;
    assign out_data = data_q;
    assign out_pc4  = pc4_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage with IF/ID register, skid slot,
// single-outstanding memory reads and redirect squashing.
module inst_fetch
    import mips_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iStall,
    input  logic              iRedirect,
    input  logic [ADDR_W-1:0] iTarget,
    output logic              oImemReq,
    output logic [ADDR_W-1:0] oImemAddr,
    input  logic              iImemAck,
    input  logic [31:0]       iImemData,
    output logic              oValid,
    output logic [31:0]       oInstr,
    output logic [ADDR_W-1:0] oPC4,
    output logic [5:0]        oOp,
    output logic [5:0]        oFunc,
    output logic [4:0]        oRs,
    output logic [4:0]        oRt,
    output logic [4:0]        oRd,
    output logic [4:0]        oShamt,
    output logic [31:0]       oImm
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    logic              ack;
    logic              accept;
    logic [ADDR_W-1:0] ack_pc4;
    logic              skid_load, skid_unload, skid_flush;
    logic              skid_valid, skid_full_next;
    logic [31:0]       skid_data;
    logic [ADDR_W-1:0] skid_pc4;
    logic              unused_tgt;

    assign unused_tgt = ^iTarget[1:0];

    // Acks are only meaningful while a request is outstanding.
    assign ack     = req_q & iImemAck;
    assign accept  = ack & (state_q == S_WAIT) & ~iRedirect;
    assign ack_pc4 = addr_q + WORD_BYTES;

    if_skid #(
        .ADDR_W(ADDR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (skid_flush),
        .in_data  (iImemData),
        .in_pc4   (ack_pc4),
        .valid    (skid_valid),
        .out_data (skid_data),
        .out_pc4  (skid_pc4)
    );

    always_comb begin
        pc_d        = pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        if (iRedirect) begin
            valid_d    = 1'b0;
            skid_flush = 1'b1;
            pc_d       = {iTarget[ADDR_W-1:2], 2'b00};
        end else if (!iStall) begin
            if (skid_valid) begin
                instr_d     = skid_data;
                pc4_d       = skid_pc4;
                valid_d     = 1'b1;
                skid_unload = 1'b1;
                skid_load   = accept;
            end else if (accept) begin
                instr_d = iImemData;
                pc4_d   = ack_pc4;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            skid_load = accept;
        end
    end

    assign skid_full_next = skid_load
                          | (skid_valid & ~skid_unload & ~skid_flush);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (!iRedirect && !skid_valid) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            S_WAIT: begin
                if (ack && iRedirect) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end else if (ack) begin
                    if (!skid_full_next) begin
                        addr_d = ack_pc4;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end else if (iRedirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // The pc advances past every accepted word, even if it lands in the skid.
    logic [ADDR_W-1:0] pc_next;
    assign pc_next = accept ? ack_pc4 : pc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_next;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign oImemReq  = req_q;
    assign oImemAddr = addr_q;
    assign oValid    = valid_q;
    assign oInstr    = instr_q;
    assign oPC4      = pc4_q;

    assign oOp    = instr_q[31:26];
    assign oRs    = instr_q[25:21];
    assign oRt    = instr_q[20:16];
    assign oRd    = instr_q[15:11];
    assign oShamt = instr_q[10:6];
    assign oFunc  = instr_q[5:0];
    assign oImm   = sext16(instr_q[15:0]);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, stall/skid, redirects,
// field decode, address wrap and reset with a full skid.
module tb_inst_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        iStall;
    logic        iRedirect;
    logic [31:0] iTarget;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck;
    logic [31:0] iImemData;
    logic        oValid;
    logic [31:0] oInstr;
    logic [31:0] oPC4;
    logic [5:0]  oOp, oFunc;
    logic [4:0]  oRs, oRt, oRd, oShamt;
    logic [31:0] oImm;

    logic        auto_ack;
    logic        man_ack;
    logic        ovr_en;
    logic [31:0] ovr_data;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    assign iImemAck  = auto_ack ? oImemReq : man_ack;
    assign iImemData = ovr_en ? ovr_data : mem_word(oImemAddr);

    inst_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iStall    (iStall),
        .iRedirect (iRedirect),
        .iTarget   (iTarget),
        .oImemReq  (oImemReq),
        .oImemAddr (oImemAddr),
        .iImemAck  (iImemAck),
        .iImemData (iImemData),
        .oValid    (oValid),
        .oInstr    (oInstr),
        .oPC4      (oPC4),
        .oOp       (oOp),
        .oFunc     (oFunc),
        .oRs       (oRs),
        .oRt       (oRt),
        .oRd       (oRd),
        .oShamt    (oShamt),
        .oImm      (oImm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        iStall    = 1'b0;
        iRedirect = 1'b0;
        iTarget   = '0;
        man_ack   = 1'b0;
        ovr_en    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        auto_ack = 1'b1;
        do_reset();
        n_tot++;
        if (oImemReq !== 1'b0)
            $display("FAIL rst_req: got %b want 0", oImemReq);
        else n_pass++;
        n_tot++;
        if (oImemAddr !== 32'h0)
            $display("FAIL rst_addr: got %h want 0", oImemAddr);
        else n_pass++;
        n_tot++;
        if (oValid !== 1'b0 || oInstr !== NOP_WORD || oPC4 !== 32'h0)
            $display("FAIL rst_out: got %b %h %h want 0", oValid, oInstr, oPC4);
        else n_pass++;
        n_tot++;
        if ({oOp, oRs, oRt, oRd, oShamt, oFunc} !== 32'h0 || oImm !== 32'h0)
            $display("FAIL rst_fields: got %h %h want 0",
                     {oOp, oRs, oRt, oRd, oShamt, oFunc}, oImm);
        else n_pass++;
    endtask

    task automatic test_stream();
        auto_ack = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tot++;
            if (oImemReq !== 1'b1 || oImemAddr !== 32'(4 * i))
                $display("FAIL stream_req%0d: got %b %h want 1 %h",
                         i, oImemReq, oImemAddr, 32'(4 * i));
            else n_pass++;
            n_tot++;
            if (i == 0) begin
                if (oValid !== 1'b0)
                    $display("FAIL stream_v0: got %b want 0", oValid);
                else n_pass++;
            end else begin
                if (oValid !== 1'b1 || oInstr !== mem_word(32'(4 * (i - 1)))
                    || oPC4 !== 32'(4 * i))
                    $display("FAIL stream_out%0d: got %b %h %h want 1 %h %h",
                             i, oValid, oInstr, oPC4,
                             mem_word(32'(4 * (i - 1))), 32'(4 * i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall_skid();
        auto_ack = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        iStall = 1'b1;
        tick();
        n_tot++;
        if (oImemReq !== 1'b0 || oValid !== 1'b1 || oInstr !== mem_word(32'h4))
            $display("FAIL stall_hold: got %b %b %h want 0 1 %h",
                     oImemReq, oValid, oInstr, mem_word(32'h4));
        else n_pass++;
        tick();
        n_tot++;
        if (oImemReq !== 1'b0 || oInstr !== mem_word(32'h4))
            $display("FAIL stall_hold2: got %b %h want 0 %h",
                     oImemReq, oInstr, mem_word(32'h4));
        else n_pass++;
        iStall = 1'b0;
        tick();
        n_tot++;
        if (oValid !== 1'b1 || oInstr !== mem_word(32'h8) || oPC4 !== 32'hC)
            $display("FAIL skid_out: got %b %h %h want 1 %h c",
                     oValid, oInstr, oPC4, mem_word(32'h8));
        else n_pass++;
        tick();
        n_tot++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'hC)
            $display("FAIL skid_refetch: got %b %h want 1 c", oImemReq, oImemAddr);
        else n_pass++;
        tick();
        n_tot++;
        if (oValid !== 1'b1 || oInstr !== mem_word(32'hC) || oPC4 !== 32'h10)
            $display("FAIL skid_next: got %b %h %h want 1 %h 10",
                     oValid, oInstr, oPC4, mem_word(32'hC));
        else n_pass++;
    endtask

    task automatic test_redirect_drop();
        auto_ack = 1'b0;
        do_reset();
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        n_tot++;
        if (oValid !== 1'b1 || oInstr !== mem_word(32'h0) || oImemAddr !== 32'h4)
            $display("FAIL drop_first: got %b %h %h want 1 %h 4",
                     oValid, oInstr, oImemAddr, mem_word(32'h0));
        else n_pass++;
        tick();
        iRedirect = 1'b1;
        iTarget   = 32'h100;
        tick();
        iRedirect = 1'b0;
        n_tot++;
        if (oValid !== 1'b0 || oImemReq !== 1'b1 || oImemAddr !== 32'h4)
            $display("FAIL drop_pending: got %b %b %h want 0 1 4",
                     oValid, oImemReq, oImemAddr);
        else n_pass++;
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        n_tot++;
        if (oValid !== 1'b0 || oImemReq !== 1'b0)
            $display("FAIL drop_discard: got %b %b want 0 0", oValid, oImemReq);
        else n_pass++;
        tick();
        n_tot++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'h100)
            $display("FAIL drop_target: got %b %h want 1 100", oImemReq, oImemAddr);
        else n_pass++;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        n_tot++;
        if (oValid !== 1'b1 || oInstr !== mem_word(32'h100) || oPC4 !== 32'h104)
            $display("FAIL drop_word: got %b %h %h want 1 %h 104",
                     oValid, oInstr, oPC4, mem_word(32'h100));
        else n_pass++;
    endtask

    task automatic test_redirect_ack_stall();
        auto_ack = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        iStall    = 1'b1;
        iRedirect = 1'b1;
        iTarget   = 32'h42;
        tick();
        iStall    = 1'b0;
        iRedirect = 1'b0;
        n_tot++;
        if (oValid !== 1'b0 || oImemReq !== 1'b0)
            $display("FAIL rak_clear: got %b %b want 0 0", oValid, oImemReq);
        else n_pass++;
        tick();
        n_tot++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'h40)
            $display("FAIL rak_target: got %b %h want 1 40", oImemReq, oImemAddr);
        else n_pass++;
        tick();
        n_tot++;
        if (oValid !== 1'b1 || oInstr !== mem_word(32'h40) || oPC4 !== 32'h44)
            $display("FAIL rak_word: got %b %h %h want 1 %h 44",
                     oValid, oInstr, oPC4, mem_word(32'h40));
        else n_pass++;
    endtask

    task automatic test_decode();
        auto_ack = 1'b1;
        do_reset();
        ovr_en   = 1'b1;
        ovr_data = 32'h8C51_0064;
        tick();
        tick();
        n_tot++;
        if (oOp !== OP_LW || oRs !== 5'd2 || oRt !== 5'd17
            || oImm !== 32'h0000_0064)
            $display("FAIL dec_lw: got %h %0d %0d %h want 23 2 17 64",
                     oOp, oRs, oRt, oImm);
        else n_pass++;
        n_tot++;
        if (oRd !== 5'd0 || oShamt !== 5'd1 || oFunc !== 6'h24)
            $display("FAIL dec_lw_low: got %0d %0d %h want 0 1 24",
                     oRd, oShamt, oFunc);
        else n_pass++;
        ovr_data = 32'h1000_FFFF;
        tick();
        n_tot++;
        if (oOp !== OP_BEQ || oImm !== 32'hFFFF_FFFF || oRs !== 5'd0)
            $display("FAIL dec_beq: got %h %h %0d want 04 ffffffff 0",
                     oOp, oImm, oRs);
        else n_pass++;
        ovr_en = 1'b0;
    endtask

    task automatic test_wrap();
        auto_ack = 1'b1;
        do_reset();
        tick();
        iRedirect = 1'b1;
        iTarget   = 32'hFFFF_FFFC;
        tick();
        iRedirect = 1'b0;
        tick();
        n_tot++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req: got %b %h want 1 fffffffc",
                     oImemReq, oImemAddr);
        else n_pass++;
        tick();
        n_tot++;
        if (oPC4 !== 32'h0 || oImemAddr !== 32'h0
            || oInstr !== mem_word(32'hFFFF_FFFC))
            $display("FAIL wrap_pc4: got %h %h %h want 0 0 %h",
                     oPC4, oImemAddr, oInstr, mem_word(32'hFFFF_FFFC));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        auto_ack = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        iStall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        n_tot++;
        if (oImemReq !== 1'b0 || oImemAddr !== 32'h0 || oValid !== 1'b0
            || oInstr !== 32'h0 || oPC4 !== 32'h0 || oImm !== 32'h0)
            $display("FAIL rmid_out: got %b %h %b %h %h want all 0",
                     oImemReq, oImemAddr, oValid, oInstr, oPC4);
        else n_pass++;
        reset  = 1'b0;
        iStall = 1'b0;
        tick();
        n_tot++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'h0)
            $display("FAIL rmid_req: got %b %h want 1 0", oImemReq, oImemAddr);
        else n_pass++;
        tick();
        n_tot++;
        if (oValid !== 1'b1 || oInstr !== mem_word(32'h0) || oPC4 !== 32'h4)
            $display("FAIL rmid_word: got %b %h %h want 1 %h 4",
                     oValid, oInstr, oPC4, mem_word(32'h0));
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b1;
        iStall    = 1'b0;
        iRedirect = 1'b0;
        iTarget   = '0;
        auto_ack  = 1'b0;
        man_ack   = 1'b0;
        ovr_en    = 1'b0;
        ovr_data  = '0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_drop();
        test_redirect_ack_stall();
        test_decode();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
